// File: rtl/neighbor_window_scan.sv
// Row-major scanner presenting each cell plus its 8 neighbours; windows are combinational from registered counters.
// One window per cycle; while valid & ~ready the counters, and therefore the window, hold.
module neighbor_window_scan #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic          start,
  input  logic          ready,
  output logic          valid,
  output logic [RW-1:0] cell_row,
  output logic [CW-1:0] cell_col,
  output logic          self,
  output logic          l,
  output logic          la,
  output logic          a,
  output logic          ra,
  output logic          r,
  output logic          rb,
  output logic          b,
  output logic          lb,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_nxt;
  logic [ROWS-1:0][COLS-1:0] board;
  logic last_col, last_row, accept;

  assign last_col = (cell_col == CW'(COLS - 1));
  assign last_row = (cell_row == RW'(ROWS - 1));
  assign accept   = (state == SCAN) && ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (accept && last_col && last_row) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      SCAN: begin
        valid = 1'b1;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Counters return to (0,0) after the last cell so DONE/IDLE present a deterministic window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cell_row <= '0;
      cell_col <= '0;
    end else if (state == IDLE && start) begin
      cell_row <= '0;
      cell_col <= '0;
    end else if (accept) begin
      if (last_col) begin
        cell_col <= '0;
        cell_row <= last_row ? '0 : cell_row + RW'(1);
      end else begin
        cell_col <= cell_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      board <= '0;
    end else if (state == IDLE && wr_en && int'(wr_row) < ROWS) begin
      board[wr_row] <= wr_data;
    end
  end

  logic [COLS-1:0] row_above, row_cur, row_below;
  logic [CW-1:0]   col_left, col_right;
  logic            has_left, has_right;

  always_comb begin
    row_cur   = board[cell_row];
    row_above = (cell_row != '0) ? board[cell_row - RW'(1)] : '0;
    row_below = last_row ? '0 : board[cell_row + RW'(1)];
    col_left  = cell_col - CW'(1);
    col_right = cell_col + CW'(1);
    has_left  = (cell_col != '0);
    has_right = !last_col;

    self = row_cur[cell_col];
    l    = has_left  & row_cur[col_left];
    la   = has_left  & row_above[col_left];
    a    = row_above[cell_col];
    ra   = has_right & row_above[col_right];
    r    = has_right & row_cur[col_right];
    rb   = has_right & row_below[col_right];
    b    = row_below[cell_col];
    lb   = has_left  & row_below[col_left];
  end

endmodule
